// File: rtl/bus_memory.sv
// bus_memory
// ----------
// Word-addressed memory slave for the processor memory bus. It captures a
// read/write strobe in IDLE and waits WAIT_STATES extra cycles. It then
// answers with a single-cycle oMemRdy pulse.
//
// Parameters:
//   DATA_WIDTH  - bus/word width in bits
//   DEPTH       - number of words (power of two, >= 2)
//   BASE_ADDR   - word address that maps to index 0
//   WAIT_STATES - extra cycles per access (0..15)
//   IDLE_WORD   - value on oMemData whenever oMemRdy is low
//
// Ports:
//   iClk      in   clock, rising edge
//   nRst      in   asynchronous active-low reset
//   iMemAddr  in   word address
//   iMemData  in   write data
//   iMemRead  in   read request (level)
//   iMemWrite in   write request (level)
//   oMemData  out  registered read data, valid only with oMemRdy
//   oMemRdy   out  registered one-cycle access-complete pulse
//   oFault    out  out-of-range flag, valid with oMemRdy
//
// Build option: define MEM_FAULT_EN for range checking.
//   With MEM_FAULT_EN, an out-of-range access raises oFault, its write is
//   dropped, and its read returns zeros.
//   Without it, oFault is 0 and the index wraps modulo DEPTH.

module bus_memory #(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    DEPTH       = 256,
  parameter logic [31:0]           BASE_ADDR   = 32'd0,
  parameter int                    WAIT_STATES = 2,
  parameter logic [DATA_WIDTH-1:0] IDLE_WORD   = '0
) (
  input  logic                  iClk,
  input  logic                  nRst,
  input  logic [31:0]           iMemAddr,
  input  logic [DATA_WIDTH-1:0] iMemData,
  input  logic                  iMemRead,
  input  logic                  iMemWrite,
  output logic [DATA_WIDTH-1:0] oMemData,
  output logic                  oMemRdy,
  output logic                  oFault
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  // The counter is loaded with WAIT_STATES-1, so WAIT lasts WAIT_STATES cycles.
  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [1:0]            state_reg;
  logic [3:0]            cnt_reg;
  logic [31:0]           addr_reg;
  logic [DATA_WIDTH-1:0] wdata_reg;
  logic                  rd_reg;
  logic                  wr_reg;
  logic                  rdy_reg;
  logic [DATA_WIDTH-1:0] data_reg;

  logic                  start;
  logic                  enter_resp;
  logic [31:0]           acc_addr;
  logic [DATA_WIDTH-1:0] acc_wdata;
  logic                  acc_rd;
  logic                  acc_wr;
  logic [AW-1:0]         idx;
  logic                  in_range;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] rdata;

  assign start = (state_reg == S_IDLE) && (iMemRead || iMemWrite);

  // RESP is entered from WAIT when the counter expires. With zero wait
  // states, it is entered directly on the capture edge.
  assign enter_resp = ((state_reg == S_WAIT) && (cnt_reg == 4'd0)) ||
                      (start && (WAIT_STATES == 0));

  // In the zero-wait case the commit happens on the capture edge. The live
  // bus values are used there because the latched copies do not exist yet.
  assign acc_addr  = (state_reg == S_IDLE) ? iMemAddr  : addr_reg;
  assign acc_wdata = (state_reg == S_IDLE) ? iMemData  : wdata_reg;
  assign acc_rd    = (state_reg == S_IDLE) ? iMemRead  : rd_reg;
  assign acc_wr    = (state_reg == S_IDLE) ? iMemWrite : wr_reg;

`ifdef MEM_FAULT_EN
  logic [31:0] offset;
  assign offset   = acc_addr - BASE_ADDR;
  assign idx      = offset[AW-1:0];
  assign in_range = (acc_addr >= BASE_ADDR) && (offset < 32'(DEPTH));
`else
  // Truncating to AW bits makes the addresses alias modulo DEPTH.
  assign idx      = acc_addr[AW-1:0] - BASE_ADDR[AW-1:0];
  assign in_range = 1'b1;
`endif

  // A write is never committed while reset is held. This covers a reset
  // that aborts an access and also the zero-wait path.
  assign mem_we = enter_resp && acc_wr && in_range && nRst;
  assign rdata  = in_range ? mem[idx] : '0;

  // Storage has no reset, so it keeps its contents across reset.
  always_ff @(posedge iClk) begin
    if (mem_we) begin
      mem[idx] <= acc_wdata;
    end
  end

  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      state_reg <= S_IDLE;
      cnt_reg   <= 4'd0;
      addr_reg  <= 32'd0;
      wdata_reg <= '0;
      rd_reg    <= 1'b0;
      wr_reg    <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            addr_reg  <= iMemAddr;
            wdata_reg <= iMemData;
            rd_reg    <= iMemRead;
            wr_reg    <= iMemWrite;
            if (WAIT_STATES == 0) begin
              state_reg <= S_RESP;
            end else begin
              state_reg <= S_WAIT;
              cnt_reg   <= WAIT_LOAD;
            end
          end
        end
        S_WAIT: begin
          if (cnt_reg == 4'd0) begin
            state_reg <= S_RESP;
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end
        S_RESP:  state_reg <= S_IDLE;
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  // The output registers load on the edge that enters RESP and clear on the
  // next edge. RESP is never re-entered back to back, so the pulse is one
  // cycle wide. The read happens in the same cycle as the write, so it
  // returns the pre-write contents.
  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      rdy_reg  <= 1'b0;
      data_reg <= IDLE_WORD;
    end else if (enter_resp) begin
      rdy_reg  <= 1'b1;
      data_reg <= acc_rd ? rdata : IDLE_WORD;
    end else begin
      rdy_reg  <= 1'b0;
      data_reg <= IDLE_WORD;
    end
  end

`ifdef MEM_FAULT_EN
  logic fault_reg;
  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      fault_reg <= 1'b0;
    end else begin
      fault_reg <= enter_resp && !in_range;
    end
  end
  assign oFault = fault_reg;
`else
  assign oFault = 1'b0;
`endif

  assign oMemRdy  = rdy_reg;
  assign oMemData = data_reg;

endmodule

// File: tb/tb_bus_memory.sv
// Directed bench for bus_memory.
// Instance u_a: WAIT_STATES=2, BASE_ADDR=0, DEPTH=256, IDLE_WORD=DEADBEEF.
// Instance u_b: WAIT_STATES=0, BASE_ADDR=16, DEPTH=16, IDLE_WORD=0.
// The range-handling steps follow the MEM_FAULT_EN build option.
module tb_bus_memory;

  localparam logic [31:0] A_IDLE = 32'hDEAD_BEEF;
  localparam logic [31:0] B_IDLE = 32'h0000_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        nrst;
  logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
  logic        a_rd, a_wr, b_rd, b_wr;
  logic [31:0] a_data, b_data;
  logic        a_rdy, b_rdy, a_fault, b_fault;

  int checks   = 0;
  int failures = 0;

  bus_memory #(
    .DATA_WIDTH(32), .DEPTH(256), .BASE_ADDR(32'd0), .WAIT_STATES(2), .IDLE_WORD(A_IDLE)
  ) u_a (
    .iClk(clk), .nRst(nrst), .iMemAddr(a_addr), .iMemData(a_wdata),
    .iMemRead(a_rd), .iMemWrite(a_wr), .oMemData(a_data), .oMemRdy(a_rdy),
    .oFault(a_fault)
  );

  bus_memory #(
    .DATA_WIDTH(32), .DEPTH(16), .BASE_ADDR(32'd16), .WAIT_STATES(0), .IDLE_WORD(B_IDLE)
  ) u_b (
    .iClk(clk), .nRst(nrst), .iMemAddr(b_addr), .iMemData(b_wdata),
    .iMemRead(b_rd), .iMemWrite(b_wr), .oMemData(b_data), .oMemRdy(b_rdy),
    .oFault(b_fault)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit sel, input bit rd, input bit wr,
                       input logic [31:0] addr, input logic [31:0] wdata);
    if (sel) begin
      b_rd = rd; b_wr = wr; b_addr = addr; b_wdata = wdata;
    end else begin
      a_rd = rd; a_wr = wr; a_addr = addr; a_wdata = wdata;
    end
  endtask

  // One access. Strobes are presented until the capture edge E0. The cycles
  // E0..E0+ws+1 are then checked: ready high only after E0+ws, data equal
  // to exp there and to the idle word elsewhere, and fault only with ready.
  task automatic access(input bit sel, input bit rd, input bit wr,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp, input bit ef, input bit cd,
                        input string tag);
    int          ws;
    logic [31:0] idle;
    logic        rdy, flt;
    logic [31:0] d;
    ws   = sel ? 0 : 2;
    idle = sel ? B_IDLE : A_IDLE;
    drive(sel, rd, wr, addr, wdata);
    @(posedge clk);
    #1 drive(sel, 1'b0, 1'b0, addr, wdata);
    for (int i = 0; i <= ws + 1; i++) begin
      @(negedge clk);
      rdy = sel ? b_rdy : a_rdy;
      flt = sel ? b_fault : a_fault;
      d   = sel ? b_data : a_data;
      chk($sformatf("%s rdy c%0d", tag, i), {31'd0, rdy}, (i == ws) ? 32'd1 : 32'd0);
      chk($sformatf("%s fault c%0d", tag, i), {31'd0, flt},
          (i == ws) ? {31'd0, ef} : 32'd0);
      if (cd) chk($sformatf("%s data c%0d", tag, i), d, (i == ws) ? exp : idle);
    end
    $display("txn %s sel=%0d rd=%0d wr=%0d addr=%0d wdata=%0d", tag, sel, rd, wr, addr, wdata);
  endtask

  initial begin
    nrst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);

    // Reset held with a read strobe active: the block stays quiet.
    drive(1'b0, 1'b1, 1'b0, 32'd7, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("in_reset rdy c%0d", i), {31'd0, a_rdy}, 32'd0);
      chk($sformatf("in_reset data c%0d", i), a_data, A_IDLE);
    end
    nrst = 1'b1;
    access(1'b0, 1'b1, 1'b0, 32'd7, 32'd0, 32'd0, 1'b0, 1'b0, "after_reset_rd7");

    // Write then read back.
    access(1'b0, 1'b0, 1'b1, 32'd7, 32'd55, 32'd0, 1'b0, 1'b0, "wr7_55");
    access(1'b0, 1'b1, 1'b0, 32'd7, 32'd0, 32'd55, 1'b0, 1'b1, "rd7");

    // Read and write together return the old contents.
    access(1'b0, 1'b0, 1'b1, 32'd3, 32'd10, 32'd0, 1'b0, 1'b0, "wr3_10");
    access(1'b0, 1'b1, 1'b1, 32'd3, 32'd20, 32'd10, 1'b0, 1'b1, "rdwr3_20");
    access(1'b0, 1'b1, 1'b0, 32'd3, 32'd0, 32'd20, 1'b0, 1'b1, "rd3");

    // A reset during WAIT aborts the write of 99.
    access(1'b0, 1'b0, 1'b1, 32'd4, 32'd5, 32'd0, 1'b0, 1'b0, "wr4_5");
    drive(1'b0, 1'b0, 1'b1, 32'd4, 32'd99);
    @(posedge clk);
    #1 drive(1'b0, 1'b0, 1'b0, 32'd4, 32'd0);
    @(posedge clk);
    #1 nrst = 1'b0;
    @(negedge clk);
    chk("abort rdy in_reset", {31'd0, a_rdy}, 32'd0);
    chk("abort data in_reset", a_data, A_IDLE);
    @(posedge clk);
    #1 nrst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("abort no_rdy c%0d", i), {31'd0, a_rdy}, 32'd0);
    end
    $display("txn abort_wr4_99");
    access(1'b0, 1'b1, 1'b0, 32'd4, 32'd0, 32'd5, 1'b0, 1'b1, "rd4_after_abort");

    // Zero-wait instance: back-to-back reads with the strobe held high.
    access(1'b1, 1'b0, 1'b1, 32'd16, 32'd1, 32'd0, 1'b0, 1'b0, "b_wr16_1");
    access(1'b1, 1'b0, 1'b1, 32'd17, 32'd2, 32'd0, 1'b0, 1'b0, "b_wr17_2");
    drive(1'b1, 1'b1, 1'b0, 32'd16, 32'd0);
    @(posedge clk);
    #1 b_addr = 32'd17;
    @(negedge clk);
    chk("b2b rdy c0", {31'd0, b_rdy}, 32'd1);
    chk("b2b data c0", b_data, 32'd1);
    @(negedge clk);
    chk("b2b rdy c1", {31'd0, b_rdy}, 32'd0);
    chk("b2b data c1", b_data, B_IDLE);
    @(posedge clk);
    #1 drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    chk("b2b rdy c2", {31'd0, b_rdy}, 32'd1);
    chk("b2b data c2", b_data, 32'd2);
    @(negedge clk);
    chk("b2b rdy c3", {31'd0, b_rdy}, 32'd0);
    $display("txn b2b_rd16_rd17");

    // Range handling on DEPTH=16, BASE_ADDR=16.
`ifdef MEM_FAULT_EN
    access(1'b1, 1'b0, 1'b1, 32'd24, 32'd33, 32'd0, 1'b0, 1'b0, "b_wr24_33");
    access(1'b1, 1'b0, 1'b1, 32'd40, 32'd44, 32'd0, 1'b1, 1'b0, "b_wr40_oor");
    access(1'b1, 1'b1, 1'b0, 32'd40, 32'd0, 32'd0, 1'b1, 1'b1, "b_rd40_oor");
    access(1'b1, 1'b1, 1'b0, 32'd24, 32'd0, 32'd33, 1'b0, 1'b1, "b_rd24");
    access(1'b1, 1'b1, 1'b0, 32'd16, 32'd0, 32'd1, 1'b0, 1'b1, "b_rd16");
`else
    access(1'b1, 1'b0, 1'b1, 32'd32, 32'd77, 32'd0, 1'b0, 1'b0, "b_wr32_77");
    access(1'b1, 1'b1, 1'b0, 32'd16, 32'd0, 32'd77, 1'b0, 1'b1, "b_rd16_alias");
    access(1'b1, 1'b1, 1'b0, 32'd17, 32'd0, 32'd2, 1'b0, 1'b1, "b_rd17");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
